// File: rtl/softmax_result_drain.sv
// ============================================================================
//  Module   : softmax_result_drain
//  Purpose  : Buffers softmax probability vectors with their argmax and drains
//             each one as a word-serial valid/ready frame ending in a class word.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module softmax_result_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CLASS  = 2,
  parameter int DEPTH      = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_WIDTH*NUM_CLASS-1:0]  i_data,
  input  logic                             valid_in,
  output logic [DATA_WIDTH-1:0]            o_word,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic                             o_last,
  output logic                             full,
  output logic                             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(NUM_CLASS + 1);
  localparam int CLS_W = $clog2(NUM_CLASS);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_CLASS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_CLASS = 2'd2
  } state_t;

  logic [DATA_WIDTH*NUM_CLASS-1:0] r_mem_vec [DEPTH];
  logic [CLS_W-1:0]                r_mem_cls [DEPTH];
  logic [PTR_W-1:0]                r_wptr, r_rptr, w_rptr_nxt;
  logic [CNT_W-1:0]                r_count;
  logic [IDX_W-1:0]                r_idx, w_idx_n;
  state_t                          r_state, w_state_n;
  logic [DATA_WIDTH-1:0]           w_word_n;
  logic                            w_valid_n, w_last_n;
  logic                            w_push, w_pop, w_hs;
  logic [CLS_W-1:0]                w_best_cls;
  logic [DATA_WIDTH-2:0]           w_best_key;

  function automatic logic [DATA_WIDTH-2:0] rank_key(input logic [DATA_WIDTH-1:0] w);
    // Negative values (including -0) collapse to the lowest rank.
    rank_key = w[DATA_WIDTH-1] ? '0 : w[DATA_WIDTH-2:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sel_word(
    input logic [DATA_WIDTH*NUM_CLASS-1:0] vec,
    input logic [IDX_W-1:0]                sel
  );
    sel_word = '0;
    for (int k = 0; k < NUM_CLASS; k++) begin
      if (sel == IDX_W'(k)) sel_word = vec[k*DATA_WIDTH +: DATA_WIDTH];
    end
  endfunction

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_best_cls = '0;
    w_best_key = rank_key(i_data[0 +: DATA_WIDTH]);
    for (int k = 1; k < NUM_CLASS; k++) begin
      if (rank_key(i_data[k*DATA_WIDTH +: DATA_WIDTH]) > w_best_key) begin
        w_best_key = rank_key(i_data[k*DATA_WIDTH +: DATA_WIDTH]);
        w_best_cls = CLS_W'(k);
      end
    end
  end

  assign full       = (r_count == C_DEPTH);
  assign w_push     = valid_in & ~full;
  assign w_hs       = o_valid & o_ready;
  assign w_rptr_nxt = r_rptr + PTR_W'(1);

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_word_n  = o_word;
    w_valid_n = o_valid;
    w_last_n  = o_last;
    w_pop     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_word_n  = sel_word(r_mem_vec[r_rptr], '0);
          w_valid_n = 1'b1;
          w_idx_n   = '0;
          w_state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          w_idx_n = r_idx + IDX_W'(1);
          if (r_idx == C_LAST_IDX) begin
            w_word_n  = DATA_WIDTH'(r_mem_cls[r_rptr]);
            w_last_n  = 1'b1;
            w_state_n = S_CLASS;
          end else begin
            w_word_n = sel_word(r_mem_vec[r_rptr], r_idx + IDX_W'(1));
          end
        end
      end
      S_CLASS: begin
        if (w_hs) begin
          w_pop    = 1'b1;
          w_last_n = 1'b0;
          // Next entry is already resident, so chain straight into it.
          if (r_count > C_ONE) begin
            w_word_n  = sel_word(r_mem_vec[w_rptr_nxt], '0);
            w_idx_n   = '0;
            w_state_n = S_SEND;
          end else begin
            w_valid_n = 1'b0;
            w_state_n = S_IDLE;
          end
        end
      end
      default: begin
        w_valid_n = 1'b0;
        w_last_n  = 1'b0;
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_vec[r_wptr] <= i_data;
      r_mem_cls[r_wptr] <= w_best_cls;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      o_word   <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      o_word  <= w_word_n;
      o_valid <= w_valid_n;
      o_last  <= w_last_n;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= w_rptr_nxt;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (valid_in & full) overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_softmax_result_drain.sv
// ============================================================================
//  Module   : tb_softmax_result_drain
//  Purpose  : Scoreboard bench for softmax_result_drain frames and flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_softmax_result_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] i_data = '0;
  logic        valid_in = 1'b0;
  logic [31:0] o_word;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic        o_last;
  logic        full;
  logic        overflow;

  typedef struct {
    logic [31:0] w;
    logic        l;
  } exp_t;

  exp_t        sb_q[$];
  int          n_pass  = 0;
  int          n_total = 0;
  logic        r_prev_stall = 1'b0;
  logic [32:0] r_prev_out   = '0;

  softmax_result_drain #(.DATA_WIDTH(32), .NUM_CLASS(2), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in),
    .o_word(o_word), .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last),
    .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_class(input logic [31:0] p0, input logic [31:0] p1);
    logic [30:0] k0, k1;
    k0 = p0[31] ? 31'd0 : p0[30:0];
    k1 = p1[31] ? 31'd0 : p1[30:0];
    return (k1 > k0) ? 32'd1 : 32'd0;
  endfunction

  // Drives one vector for a single cycle; the capture edge has passed on return.
  task automatic send_vec(input logic [31:0] p0, input logic [31:0] p1, input bit drop);
    if (!drop) begin
      sb_q.push_back('{w: p0, l: 1'b0});
      sb_q.push_back('{w: p1, l: 1'b0});
      sb_q.push_back('{w: ref_class(p0, p1), l: 1'b1});
    end
    i_data   = {p1, p0};
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_q.size() != 0 || o_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("drain_timeout", 64'd0, 64'd1);
  endtask

  // Output monitor: scoreboard on handshakes, stability during stalls.
  always @(negedge clk) begin
    if (rst) begin
      r_prev_stall = 1'b0;
    end else begin
      if (r_prev_stall) begin
        check("stall_valid", {63'd0, o_valid}, 64'd1);
        check("stall_hold", {31'd0, o_last, o_word}, {31'd0, r_prev_out});
      end
      if (o_valid && o_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_word", {32'd0, o_word}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("word", {32'd0, o_word}, {32'd0, e.w});
          check("last", {63'd0, o_last}, {63'd0, e.l});
        end
      end
      r_prev_stall = o_valid && !o_ready;
      r_prev_out   = {o_last, o_word};
    end
  end

  initial begin
    int bp[6] = '{0, 1, 0, 0, 1, 1};
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_word", {32'd0, o_word}, 64'd0);
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_last", {63'd0, o_last}, 64'd0);
    check("rst_full", {63'd0, full}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);

    // Single vector: valid appears one cycle after capture, three contiguous words.
    o_ready = 1'b1;
    send_vec(32'h3E80_0000, 32'h3F40_0000, 1'b0);
    check("lat_not_yet", {63'd0, o_valid}, 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("single_contig", {63'd0, o_valid}, 64'd1);
      tick();
    end
    check("single_end", {63'd0, o_valid}, 64'd0);
    wait_drain();

    // Backpressure pattern applied once the frame is presented.
    o_ready = 1'b0;
    send_vec(32'h3E80_0000, 32'h3F40_0000, 1'b0);
    tick();
    check("bp_valid", {63'd0, o_valid}, 64'd1);
    for (int k = 0; k < 6; k++) begin
      o_ready = bp[k][0];
      tick();
    end
    check("bp_done", {63'd0, o_valid}, 64'd0);
    check("bp_sb_empty", 64'(sb_q.size()), 64'd0);
    o_ready = 1'b1;
    wait_drain();

    // Tie resolves to index 0; a negative probability ranks lowest.
    send_vec(32'h3F00_0000, 32'h3F00_0000, 1'b0);
    wait_drain();
    send_vec(32'hBF80_0000, 32'h3F80_0000, 1'b0);
    wait_drain();
    send_vec(32'h8000_0000, 32'h0000_0000, 1'b0);
    wait_drain();

    // Overflow: fill with the stream stalled, fifth vector dropped.
    o_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_vec(32'h3000_0000 + k, 32'h3000_0010 - k, 1'b0);
    check("full_set", {63'd0, full}, 64'd1);
    check("ovf_clear", {63'd0, overflow}, 64'd0);
    send_vec(32'h1234_5678, 32'h0, 1'b1);
    check("ovf_set", {63'd0, overflow}, 64'd1);
    check("full_hold", {63'd0, full}, 64'd1);
    o_ready = 1'b1;
    wait_drain();
    check("full_clear", {63'd0, full}, 64'd0);
    check("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Reset after the first word handshake discards the partial frame.
    send_vec(32'h3F80_0000, 32'h3E00_0000, 1'b0);
    tick();
    check("mid_valid", {63'd0, o_valid}, 64'd1);
    tick();
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("mid_rst_valid", {63'd0, o_valid}, 64'd0);
    check("mid_rst_full", {63'd0, full}, 64'd0);
    check("mid_rst_ovf", {63'd0, overflow}, 64'd0);
    tick();
    rst = 1'b0;
    tick();
    send_vec(32'h0100_0000, 32'h0200_0000, 1'b0);
    wait_drain();

    // Back-to-back vectors: six words with no idle cycle.
    send_vec(32'h3D00_0000, 32'h3C00_0000, 1'b0);
    send_vec(32'h3A00_0000, 32'h3B00_0000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      check("b2b_contig", {63'd0, o_valid}, 64'd1);
      tick();
    end
    check("b2b_end", {63'd0, o_valid}, 64'd0);
    wait_drain();
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
